// File: rtl/psum_axis_out_fifo_pkg.sv
// Shared accelerator package: stream data width, counter limits and the clogb2 helper.
// The packer imports this package too, so the width is defined in one place.
package psum_axis_out_fifo_pkg;

  localparam int          ACC_TDATA_WIDTH = 32;
  localparam logic [15:0] OVF_CNT_MAX     = 16'hFFFF;

  // Ceiling log2, used for pointer widths.
  function automatic int clogb2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/psum_axis_out_fifo_mem.sv
// sync_fifo_mem: a register array with its own write and read pointers.
// Reads are combinational from the read pointer; both pointers wrap at DEPTH.
module sync_fifo_mem
  import psum_axis_out_fifo_pkg::*;
#(
  parameter int WIDTH = ACC_TDATA_WIDTH + 1,
  parameter int DEPTH = 16,
  parameter int AW    = clogb2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // DEPTH is a power of two, so natural pointer overflow gives the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/psum_axis_out_fifo.sv
// Output FIFO between the psum word packer and the AXI4-Stream master, with a one-entry output register.
// Define PSUM_AXIS_OUT_OVF_CNT_EN to add the 16-bit saturating overflow_cnt output.
module psum_axis_out_fifo
  import psum_axis_out_fifo_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = ACC_TDATA_WIDTH,
  parameter int FIFO_DEPTH           = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic                              in_last,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   in_data,
  input  logic                              clear_status,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic                              m_axis_tlast,
  output logic [clogb2(FIFO_DEPTH):0]       fifo_count,
  output logic                              overflow
`ifdef PSUM_AXIS_OUT_OVF_CNT_EN
  ,
  output logic [15:0]                       overflow_cnt
`endif
);

  localparam int              AW         = clogb2(FIFO_DEPTH);
  localparam int              CW         = AW + 1;
  localparam logic [CW-1:0]   FULL_COUNT = CW'(FIFO_DEPTH);

  logic                            fifo_full;
  logic                            fifo_empty;
  logic                            wr_accept;
  logic                            wr_drop;
  logic                            out_free;
  logic                            pop;
  logic                            pending_last;
  logic [C_M_AXIS_TDATA_WIDTH:0]   head;

  // Fullness is taken from the pre-edge count, so a same-cycle pop never frees room.
  assign fifo_full  = (fifo_count == FULL_COUNT);
  assign fifo_empty = (fifo_count == '0);
  assign wr_accept  = in_valid & ~fifo_full;
  assign wr_drop    = in_valid & fifo_full;
  assign out_free   = ~m_axis_tvalid | m_axis_tready;
  assign pop        = out_free & ~fifo_empty;

  sync_fifo_mem #(
    .WIDTH (C_M_AXIS_TDATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .rd_en   (pop),
    .wr_data ({in_last | pending_last, in_data}),
    .rd_data (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_count <= '0;
    end else begin
      case ({wr_accept, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // A layer-end marker that arrives without a word is attached to the next accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_last <= 1'b0;
    end else if (wr_accept) begin
      pending_last <= 1'b0;
    end else if (in_last && !in_valid) begin
      pending_last <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (out_free) begin
      m_axis_tvalid <= ~fifo_empty;
      if (!fifo_empty) begin
        m_axis_tlast <= head[C_M_AXIS_TDATA_WIDTH];
        m_axis_tdata <= head[C_M_AXIS_TDATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_drop) begin
      overflow <= 1'b1;
    end else if (clear_status) begin
      overflow <= 1'b0;
    end
  end

`ifdef PSUM_AXIS_OUT_OVF_CNT_EN
  // A drop coinciding with clear_status restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_cnt <= '0;
    end else if (wr_drop) begin
      if (clear_status)                     overflow_cnt <= 16'd1;
      else if (overflow_cnt != OVF_CNT_MAX) overflow_cnt <= overflow_cnt + 16'd1;
    end else if (clear_status) begin
      overflow_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_psum_axis_out_fifo.sv
// Self-checking bench for psum_axis_out_fifo: directed steps plus random traffic against a queue model.
// Build with PSUM_AXIS_OUT_OVF_CNT_EN defined to also check overflow_cnt.
module tb_psum_axis_out_fifo;

  localparam int W = 32;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_last;
  logic [W-1:0] in_data;
  logic         clear_status;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [W-1:0] m_axis_tdata;
  logic         m_axis_tlast;
  logic [4:0]   fifo_count;
  logic         overflow;
`ifdef PSUM_AXIS_OUT_OVF_CNT_EN
  logic [15:0]  overflow_cnt;
`endif

  psum_axis_out_fifo #(
    .C_M_AXIS_TDATA_WIDTH (W),
    .FIFO_DEPTH           (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_data       (in_data),
    .clear_status  (clear_status),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .fifo_count    (fifo_count),
    .overflow      (overflow)
`ifdef PSUM_AXIS_OUT_OVF_CNT_EN
    ,
    .overflow_cnt  (overflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: queued words, the word on the output, sticky status.
  logic [W:0] mq[$];
  logic       m_valid;
  logic [W:0] m_out;
  logic       m_pend;
  logic       m_ovf;
  int         m_cnt;

  logic [W:0] emitted[$];
  logic [W:0] sent[$];
  int         passed = 0;
  int         failed = 0;
  int         total  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelEdge(input logic v, input logic l, input logic [W-1:0] d,
                           input logic rdy, input logic clr, input logic r);
    int pre_size;
    logic fire;
    if (r) begin
      mq.delete();
      m_valid = 1'b0;
      m_out   = '0;
      m_pend  = 1'b0;
      m_ovf   = 1'b0;
      m_cnt   = 0;
      return;
    end
    pre_size = mq.size();
    fire = m_valid & rdy;
    if (!m_valid || fire) begin
      if (pre_size > 0) begin
        m_out   = mq.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (v && pre_size == D) begin
      m_ovf = 1'b1;
      if (clr) m_cnt = 1;
      else if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else begin
      if (clr) begin
        m_ovf = 1'b0;
        m_cnt = 0;
      end
      if (v) begin
        mq.push_back({l | m_pend, d});
        m_pend = 1'b0;
      end else if (l) begin
        m_pend = 1'b1;
      end
    end
  endtask

  // One clock cycle: drive, capture pre-edge outputs, advance the model, compare #1 after the edge.
  task automatic applyStimulus(input logic v, input logic l, input logic [W-1:0] d,
                               input logic rdy, input logic clr, input logic r);
    logic         stall;
    logic [W-1:0] hold_data;
    logic         hold_last;
    rst           = r;
    in_valid      = v;
    in_last       = l;
    in_data       = d;
    m_axis_tready = rdy;
    clear_status  = clr;
    stall     = (m_axis_tvalid === 1'b1) && !rdy && !r;
    hold_data = m_axis_tdata;
    hold_last = m_axis_tlast;
    if (!r && m_axis_tvalid === 1'b1 && rdy) emitted.push_back({m_axis_tlast, m_axis_tdata});
    @(posedge clk);
    modelEdge(v, l, d, rdy, clr, r);
    #1;
    checkOutput("tvalid", 64'(m_axis_tvalid), 64'(m_valid));
    if (m_valid) begin
      checkOutput("tdata", 64'(m_axis_tdata), 64'(m_out[W-1:0]));
      checkOutput("tlast", 64'(m_axis_tlast), 64'(m_out[W]));
    end
    checkOutput("fifo_count", 64'(fifo_count), 64'(mq.size()));
    checkOutput("overflow", 64'(overflow), 64'(m_ovf));
`ifdef PSUM_AXIS_OUT_OVF_CNT_EN
    checkOutput("overflow_cnt", 64'(overflow_cnt), 64'(m_cnt));
`endif
    if (stall) begin
      checkOutput("stall_tdata", 64'(m_axis_tdata), 64'(hold_data));
      checkOutput("stall_tlast", 64'(m_axis_tlast), 64'(hold_last));
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, W'($urandom), rdy, 1'b0, 1'b0);
  endtask

  // Leaves a marker word in the output register with an empty FIFO behind it.
  task automatic preloadMarker(input logic [W-1:0] marker);
    applyStimulus(1'b1, 1'b0, marker, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
  endtask

  initial begin
    $display("[TB] start");
    // Reset state
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("rst_tdata", 64'(m_axis_tdata), 64'd0);
    checkOutput("rst_tlast", 64'(m_axis_tlast), 64'd0);
    checkOutput("rst_count", 64'(fifo_count), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);

    // Single word latency
    applyStimulus(1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0);
    checkOutput("lat_tvalid_early", 64'(m_axis_tvalid), 64'd0);
    idle(1, 1'b1);
    checkOutput("lat_tvalid", 64'(m_axis_tvalid), 64'd1);
    checkOutput("lat_tdata", 64'(m_axis_tdata), 64'hA5A5A5A5);
    checkOutput("lat_tlast", 64'(m_axis_tlast), 64'd0);
    checkOutput("lat_count", 64'(fifo_count), 64'd0);
    idle(2, 1'b1);

    // Fill past full with the output stalled, then drain in order
    emitted.delete();
    preloadMarker(32'hFF);
    for (int i = 1; i <= 17; i++) applyStimulus(1'b1, 1'b0, W'(i), 1'b0, 1'b0, 1'b0);
    checkOutput("full_count", 64'(fifo_count), 64'd16);
    checkOutput("full_overflow", 64'(overflow), 64'd1);
    idle(20, 1'b1);
    checkOutput("drain_len", 64'(emitted.size()), 64'd17);
    if (emitted.size() == 17) begin
      checkOutput("drain_marker", 64'(emitted[0]), 64'hFF);
      for (int i = 1; i <= 16; i++) checkOutput("drain_order", 64'(emitted[i]), 64'(i));
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    checkOutput("clear_overflow", 64'(overflow), 64'd0);

    // Full FIFO with simultaneous write and pop
    preloadMarker(32'hEE);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, W'(100 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'hDEAD, 1'b1, 1'b0, 1'b0);
    checkOutput("wrpop_count", 64'(fifo_count), 64'd15);
    checkOutput("wrpop_overflow", 64'(overflow), 64'd1);
    idle(20, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Pending layer end attaches to the next word only
    emitted.delete();
    idle(3, 1'b1);
    applyStimulus(1'b0, 1'b1, '0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h5, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h6, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);
    checkOutput("pend_len", 64'(emitted.size()), 64'd2);
    if (emitted.size() == 2) begin
      checkOutput("pend_word", 64'(emitted[0]), 64'({1'b1, 32'h5}));
      checkOutput("pend_cleared", 64'(emitted[1]), 64'({1'b0, 32'h6}));
    end

    // Random traffic with tready toggling every cycle
    emitted.delete();
    sent.delete();
    begin
      int  cyc;
      logic v;
      logic l;
      logic [W-1:0] d;
      cyc = 0;
      while (sent.size() < 40 && cyc < 2000) begin
        v = (cyc % 2 == 0) && ($urandom_range(0, 1) == 1);
        l = v && ($urandom_range(0, 3) == 0);
        d = W'($urandom);
        if (v) sent.push_back({l, d});
        applyStimulus(v, l, d, cyc[0], 1'b0, 1'b0);
        cyc++;
      end
      checkOutput("rand_sent", 64'(sent.size()), 64'd40);
    end
    idle(40, 1'b1);
    checkOutput("rand_len", 64'(emitted.size()), 64'(sent.size()));
    if (emitted.size() == sent.size())
      foreach (sent[i]) checkOutput("rand_word", 64'(emitted[i]), 64'(sent[i]));
    checkOutput("rand_overflow", 64'(overflow), 64'd0);

    // Reset mid-stream discards buffered words
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, W'(200 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    checkOutput("mrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("mrst_count", 64'(fifo_count), 64'd0);
    emitted.delete();
    applyStimulus(1'b1, 1'b0, 32'h77, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    checkOutput("mrst_len", 64'(emitted.size()), 64'd1);
    if (emitted.size() == 1) checkOutput("mrst_first", 64'(emitted[0]), 64'h77);

    // Three drops, then clear
    preloadMarker(32'hCC);
    for (int i = 0; i < 19; i++) applyStimulus(1'b1, 1'b0, W'(300 + i), 1'b0, 1'b0, 1'b0);
    checkOutput("drops_overflow", 64'(overflow), 64'd1);
`ifdef PSUM_AXIS_OUT_OVF_CNT_EN
    checkOutput("drops_cnt", 64'(overflow_cnt), 64'd3);
`endif
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("drops_cleared", 64'(overflow), 64'd0);
`ifdef PSUM_AXIS_OUT_OVF_CNT_EN
    checkOutput("drops_cnt_cleared", 64'(overflow_cnt), 64'd0);
`endif
    // Drop coinciding with clear keeps overflow set
    applyStimulus(1'b1, 1'b0, 32'h1234, 1'b0, 1'b1, 1'b0);
    checkOutput("drop_clr_overflow", 64'(overflow), 64'd1);
`ifdef PSUM_AXIS_OUT_OVF_CNT_EN
    checkOutput("drop_clr_cnt", 64'(overflow_cnt), 64'd1);
`endif
    idle(20, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
